// File: rtl/reg_space_arb_pkg.sv
// Shared types and constants for the register-space arbiter.
// Holds the FSM state encoding, the grant-index width helper and the default error read data.
package reg_space_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_ACK  = 3'd2,
    WR      = 3'd3,
    ERR_ACK = 3'd4
  } state_e;

  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_space_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
// Produces a one-hot grant, the encoded grant index and an any-request flag.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int GW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [GW-1:0]    gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_any && req[(int'(ptr) + k) % N_REQ]) begin
        gnt_any = 1'b1;
        gnt_oh[(int'(ptr) + k) % N_REQ] = 1'b1;
        gnt_idx = GW'((int'(ptr) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/reg_space_arbiter.sv
// Shares one register-space slave port among N_REQ masters, round-robin,
// locked per transaction, with a watchdog that completes stalled transfers with an error.
module reg_space_arbiter
  import reg_space_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DFLT)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*ADDR_W-1:0]   m_rreq_addr,
  input  logic [N_REQ-1:0]          m_rreq_vld,
  output logic [N_REQ-1:0]          m_rreq_rdy,
  output logic [DATA_W-1:0]         m_rack_data,
  output logic [N_REQ-1:0]          m_rack_vld,
  input  logic [N_REQ-1:0]          m_rack_rdy,
  input  logic [N_REQ*ADDR_W-1:0]   m_wreq_addr,
  input  logic [N_REQ*DATA_W-1:0]   m_wreq_data,
  input  logic [N_REQ-1:0]          m_wreq_vld,
  output logic [N_REQ-1:0]          m_wreq_rdy,
  output logic [N_REQ-1:0]          m_err,
  output logic [ADDR_W-1:0]         s_rreq_addr,
  output logic                      s_rreq_vld,
  input  logic                      s_rreq_rdy,
  input  logic [DATA_W-1:0]         s_rack_data,
  input  logic                      s_rack_vld,
  output logic                      s_rack_rdy,
  output logic [ADDR_W-1:0]         s_wreq_addr,
  output logic [DATA_W-1:0]         s_wreq_data,
  output logic                      s_wreq_vld,
  input  logic                      s_wreq_rdy,
  output logic                      busy
);

  localparam int GW   = grant_w(N_REQ);
  localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  state_e            state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              err_first_q, err_first_d;

  logic [N_REQ-1:0]  arb_oh;
  logic [GW-1:0]     arb_idx;
  logic              arb_any;
  logic [GW-1:0]     grant_inc;
  logic              g_rvld, g_wvld, g_rack_rdy;
  logic              timeout, wr_to;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr (
    .req     (m_rreq_vld | m_wreq_vld),
    .ptr     (rr_ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign g_rvld     = m_rreq_vld[grant_q];
  assign g_wvld     = m_wreq_vld[grant_q];
  assign g_rack_rdy = m_rack_rdy[grant_q];
  assign grant_inc  = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
  // The watchdog fires in the last permitted cycle, so a stalled state lasts exactly TIMEOUT_CYC cycles.
  assign timeout    = (TIMEOUT_CYC != 0) && (wd_q == WD_LAST);
  assign wr_to      = (state_q == WR) && g_wvld && !s_wreq_rdy && timeout;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    err_first_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          grant_d = arb_idx;
          state_d = (|(arb_oh & m_rreq_vld)) ? RD_REQ : WR;
        end
      end
      RD_REQ: begin
        if (!g_rvld) begin
          state_d = IDLE;
        end else if (s_rreq_rdy) begin
          state_d = RD_ACK;
        end else if (timeout) begin
          state_d     = ERR_ACK;
          err_first_d = 1'b1;
        end
      end
      RD_ACK: begin
        if (s_rack_vld && g_rack_rdy) begin
          state_d  = IDLE;
          rr_ptr_d = grant_inc;
        end else if (timeout) begin
          state_d     = ERR_ACK;
          err_first_d = 1'b1;
        end
      end
      WR: begin
        if (!g_wvld) begin
          state_d = IDLE;
        end else if (s_wreq_rdy || timeout) begin
          state_d  = IDLE;
          rr_ptr_d = grant_inc;
        end
      end
      ERR_ACK: begin
        if (g_rack_rdy) begin
          state_d  = IDLE;
          rr_ptr_d = grant_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      wd_d = '0;
    end else if ((TIMEOUT_CYC != 0) &&
                 (state_q == RD_REQ || state_q == RD_ACK || state_q == WR)) begin
      wd_d = wd_q + 1'b1;
    end else begin
      wd_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      wd_q        <= '0;
      err_first_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      wd_q        <= wd_d;
      err_first_q <= err_first_d;
    end
  end

  // Outputs are decoded from the registered state/grant and the live handshake inputs.
  always_comb begin
    m_rreq_rdy  = '0;
    m_rack_vld  = '0;
    m_rack_data = '0;
    m_wreq_rdy  = '0;
    m_err       = '0;
    s_rreq_addr = '0;
    s_rreq_vld  = 1'b0;
    s_rack_rdy  = 1'b0;
    s_wreq_addr = '0;
    s_wreq_data = '0;
    s_wreq_vld  = 1'b0;
    case (state_q)
      RD_REQ: begin
        s_rreq_vld          = g_rvld;
        s_rreq_addr         = m_rreq_addr[grant_q*ADDR_W +: ADDR_W];
        m_rreq_rdy[grant_q] = s_rreq_rdy;
      end
      RD_ACK: begin
        m_rack_vld[grant_q] = s_rack_vld;
        m_rack_data         = s_rack_data;
        s_rack_rdy          = g_rack_rdy;
      end
      WR: begin
        s_wreq_vld          = g_wvld;
        s_wreq_addr         = m_wreq_addr[grant_q*ADDR_W +: ADDR_W];
        s_wreq_data         = m_wreq_data[grant_q*DATA_W +: DATA_W];
        m_wreq_rdy[grant_q] = s_wreq_rdy | wr_to;
        m_err[grant_q]      = wr_to;
      end
      ERR_ACK: begin
        m_rack_vld[grant_q] = 1'b1;
        m_rack_data         = ERR_DATA;
        m_err[grant_q]      = err_first_q;
      end
      default: ;
    endcase
    busy = (state_q != IDLE);
  end

endmodule

// File: tb/tb_reg_space_arbiter.sv
// Directed bench for reg_space_arbiter (two masters, short watchdog) with a
// transaction-level reference model checked every cycle plus literal expectations.
module tb_reg_space_arbiter;

  localparam int N  = 2;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;
  localparam int P_IDLE = 0, P_RQ = 1, P_RA = 2, P_WR = 3, P_EA = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] m_rreq_addr;
  logic [N-1:0]    m_rreq_vld, m_rreq_rdy;
  logic [DW-1:0]   m_rack_data;
  logic [N-1:0]    m_rack_vld, m_rack_rdy;
  logic [N*AW-1:0] m_wreq_addr;
  logic [N*DW-1:0] m_wreq_data;
  logic [N-1:0]    m_wreq_vld, m_wreq_rdy, m_err;
  logic [AW-1:0]   s_rreq_addr, s_wreq_addr;
  logic            s_rreq_vld, s_rreq_rdy;
  logic [DW-1:0]   s_rack_data, s_wreq_data;
  logic            s_rack_vld, s_rack_rdy;
  logic            s_wreq_vld, s_wreq_rdy;
  logic            busy;

  always #5 clk = ~clk;

  reg_space_arbiter #(
    .N_REQ       (N),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO),
    .ERR_DATA    (ERRV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_rreq_addr (m_rreq_addr),
    .m_rreq_vld  (m_rreq_vld),
    .m_rreq_rdy  (m_rreq_rdy),
    .m_rack_data (m_rack_data),
    .m_rack_vld  (m_rack_vld),
    .m_rack_rdy  (m_rack_rdy),
    .m_wreq_addr (m_wreq_addr),
    .m_wreq_data (m_wreq_data),
    .m_wreq_vld  (m_wreq_vld),
    .m_wreq_rdy  (m_wreq_rdy),
    .m_err       (m_err),
    .s_rreq_addr (s_rreq_addr),
    .s_rreq_vld  (s_rreq_vld),
    .s_rreq_rdy  (s_rreq_rdy),
    .s_rack_data (s_rack_data),
    .s_rack_vld  (s_rack_vld),
    .s_rack_rdy  (s_rack_rdy),
    .s_wreq_addr (s_wreq_addr),
    .s_wreq_data (s_wreq_data),
    .s_wreq_vld  (s_wreq_vld),
    .s_wreq_rdy  (s_wreq_rdy),
    .busy        (busy)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: which master owns the slave, in what phase, and for how long.
  int ph = P_IDLE, own = 0, ptr = 0, waited = 0;
  bit first = 1'b0;
  logic [31:0] wq[$];
  int          gaps[$];
  int          idle_run = 0;

  always @(negedge clk) begin : mon
    logic [11:0] e_ctl, a_ctl;
    logic [31:0] e_data;
    logic [63:0] e_bus, a_bus;
    logic        e_srv, e_srr, e_swv;
    logic [N-1:0] e_mrr, e_mrv, e_mwr, e_err;
    logic [AW-1:0] e_ra, e_wa;
    logic [DW-1:0] e_wd;
    bit expire, give_up, found;
    int c;

    expire = (waited + 1 >= TO);
    e_srv = 0; e_srr = 0; e_swv = 0;
    e_mrr = '0; e_mrv = '0; e_mwr = '0; e_err = '0;
    e_ra = '0; e_wa = '0; e_wd = '0; e_data = '0;
    give_up = 0;
    case (ph)
      P_RQ: begin
        e_srv = m_rreq_vld[own];
        e_ra  = m_rreq_addr[own*AW +: AW];
        e_mrr[own] = s_rreq_rdy;
      end
      P_RA: begin
        e_mrv[own] = s_rack_vld;
        e_data     = s_rack_data;
        e_srr      = m_rack_rdy[own];
      end
      P_WR: begin
        e_swv = m_wreq_vld[own];
        e_wa  = m_wreq_addr[own*AW +: AW];
        e_wd  = m_wreq_data[own*DW +: DW];
        give_up = m_wreq_vld[own] && !s_wreq_rdy && expire;
        e_mwr[own] = s_wreq_rdy || give_up;
        e_err[own] = give_up;
      end
      P_EA: begin
        e_mrv[own] = 1'b1;
        e_data     = ERRV;
        e_err[own] = first;
      end
      default: ;
    endcase
    e_ctl = {ph != P_IDLE, e_srv, e_srr, e_swv, e_mrr, e_mrv, e_mwr, e_err};
    a_ctl = {busy, s_rreq_vld, s_rack_rdy, s_wreq_vld, m_rreq_rdy, m_rack_vld, m_wreq_rdy, m_err};
    e_bus = {e_ra, e_wa, e_wd};
    a_bus = {s_rreq_addr, s_wreq_addr, s_wreq_data};

    if (chk_en) begin
      chk("cyc_ctl", 64'(a_ctl), 64'(e_ctl));
      chk("cyc_rdata", 64'(m_rack_data), 64'(e_data));
      chk("cyc_sbus", a_bus, e_bus);
    end

    if (s_wreq_vld && s_wreq_rdy) begin
      wq.push_back(s_wreq_data);
      gaps.push_back(idle_run);
      idle_run = 0;
    end else if (!busy) begin
      idle_run++;
    end

    if (rst) begin
      ph = P_IDLE; own = 0; ptr = 0; waited = 0; first = 0;
    end else begin
      case (ph)
        P_IDLE: begin
          found = 0;
          for (int k = 0; k < N; k++) begin
            c = (ptr + k) % N;
            if (!found && (m_rreq_vld[c] || m_wreq_vld[c])) begin
              found = 1; own = c; waited = 0;
              ph = m_rreq_vld[c] ? P_RQ : P_WR;
            end
          end
        end
        P_RQ: begin
          if (!m_rreq_vld[own]) begin ph = P_IDLE; waited = 0; end
          else if (s_rreq_rdy) begin ph = P_RA; waited = 0; end
          else if (expire) begin ph = P_EA; first = 1; waited = 0; end
          else waited++;
        end
        P_RA: begin
          if (s_rack_vld && m_rack_rdy[own]) begin ph = P_IDLE; ptr = (own + 1) % N; waited = 0; end
          else if (expire) begin ph = P_EA; first = 1; waited = 0; end
          else waited++;
        end
        P_WR: begin
          if (!m_wreq_vld[own]) begin ph = P_IDLE; waited = 0; end
          else if (s_wreq_rdy || expire) begin ph = P_IDLE; ptr = (own + 1) % N; waited = 0; end
          else waited++;
        end
        P_EA: begin
          first = 0;
          if (m_rack_rdy[own]) begin ph = P_IDLE; ptr = (own + 1) % N; end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin : guard
    #200000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int base, cnt;
    rst = 1'b1;
    m_rreq_addr = '0; m_rreq_vld = '0; m_rack_rdy = '0;
    m_wreq_addr = '0; m_wreq_data = '0; m_wreq_vld = '0;
    s_rreq_rdy = 1'b0; s_rack_data = '0; s_rack_vld = 1'b0; s_wreq_rdy = 1'b0;

    step();
    chk_en = 1'b1;
    step();
    sample();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outs", 64'({s_rreq_vld, s_wreq_vld, s_rack_rdy, m_rack_vld, m_err, m_wreq_rdy}), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Contention: both masters hold writes continuously.
    base = wq.size();
    m_wreq_addr = {16'h0020, 16'h0010};
    m_wreq_data = {32'h0000_000B, 32'h0000_000A};
    m_wreq_vld  = 2'b11;
    s_wreq_rdy  = 1'b1;
    for (int i = 0; i < 40 && wq.size() < base + 4; i++) step();
    m_wreq_vld = 2'b00;
    s_wreq_rdy = 1'b0;
    chk("cont_count", 64'(wq.size() - base), 64'd4);
    chk("cont_w0", 64'(wq[base + 0]), 64'h0000_000A);
    chk("cont_w1", 64'(wq[base + 1]), 64'h0000_000B);
    chk("cont_w2", 64'(wq[base + 2]), 64'h0000_000A);
    chk("cont_w3", 64'(wq[base + 3]), 64'h0000_000B);
    for (int i = 1; i < 4; i++) chk("cont_gap", 64'(gaps[base + i] >= 1), 64'd1);
    step();

    // Single read by master0, slave accepts on the third RD_REQ cycle.
    m_rreq_addr = {16'h0099, 16'h0004};
    m_rreq_vld  = 2'b01;
    step();
    sample();
    chk("rd_addr", 64'(s_rreq_addr), 64'h0004);
    chk("rd_wait_rdy", 64'(m_rreq_rdy), 64'd0);
    step();
    step();
    s_rreq_rdy = 1'b1;
    sample();
    chk("rd_rdy", 64'(m_rreq_rdy), 64'b01);
    step();
    m_rreq_vld  = 2'b00;
    s_rreq_rdy  = 1'b0;
    s_rack_data = 32'h1234_5678;
    s_rack_vld  = 1'b1;
    m_rack_rdy  = 2'b01;
    sample();
    chk("rd_data", 64'(m_rack_data), 64'h1234_5678);
    chk("rd_vld", 64'(m_rack_vld), 64'b01);
    step();
    s_rack_vld = 1'b0;
    m_rack_rdy = 2'b00;
    step();

    // Pointer now at master1: a simultaneous write pair goes B then A.
    base = wq.size();
    m_wreq_vld = 2'b11;
    s_wreq_rdy = 1'b1;
    for (int i = 0; i < 40 && wq.size() < base + 2; i++) step();
    m_wreq_vld = 2'b00;
    s_wreq_rdy = 1'b0;
    chk("ptr_first", 64'(wq[base + 0]), 64'h0000_000B);
    chk("ptr_second", 64'(wq[base + 1]), 64'h0000_000A);
    step();

    // Master1 raises read and write together: read goes first.
    base = wq.size();
    m_rreq_addr = {16'h0040, 16'h0004};
    m_wreq_data = {32'h0000_00C0, 32'h0000_000A};
    m_rreq_vld  = 2'b10;
    m_wreq_vld  = 2'b10;
    s_rreq_rdy  = 1'b1;
    s_wreq_rdy  = 1'b1;
    step();
    sample();
    chk("same_rd_first", 64'({s_rreq_vld, s_wreq_vld}), 64'b10);
    chk("same_raddr", 64'(s_rreq_addr), 64'h0040);
    step();
    m_rreq_vld  = 2'b00;
    s_rreq_rdy  = 1'b0;
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h0BAD_F00D;
    m_rack_rdy  = 2'b10;
    sample();
    chk("same_rd_data", 64'({m_rack_vld, m_rack_data}), {30'd0, 2'b10, 32'h0BAD_F00D});
    step();
    s_rack_vld = 1'b0;
    m_rack_rdy = 2'b00;
    for (int i = 0; i < 20 && wq.size() < base + 1; i++) step();
    m_wreq_vld = 2'b00;
    s_wreq_rdy = 1'b0;
    chk("same_wr_after", 64'(wq[base + 0]), 64'h0000_00C0);
    step();

    // Read timeout: slave never returns data.
    m_rreq_addr = {16'h0040, 16'h0008};
    m_rreq_vld  = 2'b01;
    s_rreq_rdy  = 1'b1;
    step();
    step();
    m_rreq_vld = 2'b00;
    s_rreq_rdy = 1'b0;
    cnt = 0;
    sample();
    while (!m_rack_vld[0] && cnt < 20) begin
      step();
      sample();
      cnt++;
    end
    chk("rto_cycles", 64'(cnt), 64'd4);
    chk("rto_data", 64'(m_rack_data), 64'(ERRV));
    chk("rto_err", 64'(m_err), 64'b01);
    step();
    sample();
    chk("rto_err_once", 64'(m_err), 64'd0);
    chk("rto_hold", 64'(m_rack_vld), 64'b01);
    step();
    m_rack_rdy = 2'b01;
    step();
    m_rack_rdy = 2'b00;
    sample();
    chk("rto_idle", 64'(busy), 64'd0);
    step();

    // Write timeout: slave never ready.
    m_wreq_addr = {16'h0050, 16'h0010};
    m_wreq_data = {32'h0000_00D0, 32'h0000_000A};
    m_wreq_vld  = 2'b10;
    step();
    cnt = 0;
    sample();
    while (!m_wreq_rdy[1] && cnt < 20) begin
      step();
      sample();
      cnt++;
    end
    chk("wto_cycle", 64'(cnt), 64'd3);
    chk("wto_err", 64'(m_err), 64'b10);
    step();
    m_wreq_vld = 2'b00;
    sample();
    chk("wto_idle", 64'({busy, m_wreq_rdy, m_err}), 64'd0);
    step();

    // Reset while a read waits in RD_ACK.
    m_rreq_addr = {16'h0040, 16'h000C};
    m_rreq_vld  = 2'b01;
    s_rreq_rdy  = 1'b1;
    step();
    step();
    m_rreq_vld = 2'b00;
    s_rreq_rdy = 1'b0;
    sample();
    chk("rstmid_busy", 64'(busy), 64'd1);
    step();
    rst = 1'b1;
    step();
    sample();
    chk("rstmid_outs", 64'({busy, s_rreq_vld, s_rack_rdy, s_wreq_vld, m_rreq_rdy, m_rack_vld, m_wreq_rdy, m_err}), 64'd0);
    step();
    rst = 1'b0;
    s_rack_vld  = 1'b1;
    s_rack_data = 32'h0000_0055;
    m_rack_rdy  = 2'b01;
    sample();
    chk("stale_ack", 64'({m_rack_vld, s_rack_rdy}), 64'd0);
    step();
    sample();
    chk("stale_ack2", 64'({m_rack_vld, s_rack_rdy, busy}), 64'd0);
    step();
    s_rack_vld = 1'b0;
    m_rack_rdy = 2'b00;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_space_arbiter.md
Name: reg_space_arbiter

Overview:
- Shares one register-space slave port (rreq/rack/wreq valid-ready triplet, as exposed by the RegSpaceBase_* banks) among N_REQ masters, for example the APB bridge plus a debug/DMA master.
- Round-robin grant, locked for one complete transaction: read request plus read ack, or a write.
- A timeout watchdog completes the transaction with an error if the slave stalls, so no master hangs.
- Sits between the bus-bridge wrappers and the register bank instance.

Parameters:
- N_REQ, 2, number of masters (2..8).
- ADDR_W, 16, address width.
- DATA_W, 32, data width.
- TIMEOUT_CYC, 255, cycles a non-idle state may wait for the slave before timing out; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF, read data returned to the master on a timed-out read.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- m_rreq_addr  in  N_REQ*ADDR_W  per-master read address (master i at slice i).
- m_rreq_vld  in  N_REQ  read request valid.
- m_rreq_rdy  out  N_REQ  read request accepted.
- m_rack_data  out  DATA_W  read data, shared by all masters, qualified by m_rack_vld.
- m_rack_vld  out  N_REQ  read data valid.
- m_rack_rdy  in  N_REQ  master accepts read data.
- m_wreq_addr  in  N_REQ*ADDR_W  write address.
- m_wreq_data  in  N_REQ*DATA_W  write data.
- m_wreq_vld  in  N_REQ  write valid.
- m_wreq_rdy  out  N_REQ  write accepted.
- m_err  out  N_REQ  one-cycle timeout error pulse.
- s_rreq_addr  out  ADDR_W  slave read address.
- s_rreq_vld  out  1  slave read request valid.
- s_rreq_rdy  in  1  slave read request ready.
- s_rack_data  in  DATA_W  slave read data.
- s_rack_vld  in  1  slave read data valid.
- s_rack_rdy  out  1  read data accepted from slave.
- s_wreq_addr  out  ADDR_W  slave write address.
- s_wreq_data  out  DATA_W  slave write data.
- s_wreq_vld  out  1  slave write valid.
- s_wreq_rdy  in  1  slave write ready.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr_ptr=0, grant=0, watchdog=0, m_err=0.
  - Every s_* and m_* output is 0; busy=0.
  - Asserting rst mid-transaction drops all valids at the next edge; any in-flight read ack is discarded.
- FSM states: IDLE, RD_REQ, RD_ACK, WR, ERR_ACK.
- IDLE:
  - A master requests when m_rreq_vld[i] or m_wreq_vld[i] is set.
  - Pick the first requester at or after rr_ptr, wrapping modulo N_REQ.
  - Register grant. Go to RD_REQ if that master's rreq_vld=1 (a read wins over a simultaneous write from the same master), else WR.
  - No requester: stay in IDLE.
  - Arbitration costs exactly 1 cycle; no s_* valid is asserted in IDLE.
- RD_REQ:
  - s_rreq_vld = m_rreq_vld[grant]; s_rreq_addr = that master's address; m_rreq_rdy[grant] = s_rreq_rdy.
  - s_rreq_vld and s_rreq_rdy both 1: go to RD_ACK.
  - m_rreq_vld[grant] drops before acceptance: abort to IDLE, rr_ptr unchanged.
- RD_ACK:
  - m_rack_vld[grant] = s_rack_vld; m_rack_data = s_rack_data; s_rack_rdy = m_rack_rdy[grant].
  - Handshake completes: go to IDLE, rr_ptr = grant+1 mod N_REQ.
- WR:
  - s_wreq_* driven from master grant; m_wreq_rdy[grant] = s_wreq_rdy.
  - Handshake completes: go to IDLE, rr_ptr = grant+1.
  - m_wreq_vld[grant] drops before acceptance: abort to IDLE, rr_ptr unchanged.
- Non-granted masters: rdy/vld outputs are 0 at all times. All m_* and s_* outputs are combinational from registered state/grant and the live inputs.
- Watchdog:
  - Counter clears on every state change and increments each cycle while in RD_REQ, RD_ACK or WR.
  - When it reaches TIMEOUT_CYC, the outcome depends on the state:
    - RD_REQ or RD_ACK: go to ERR_ACK.
    - WR: pulse m_wreq_rdy[grant] and m_err[grant] for 1 cycle, go to IDLE, rr_ptr advances.
- ERR_ACK:
  - All s_* valids are 0.
  - m_rack_vld[grant]=1 with m_rack_data=ERR_DATA until m_rack_rdy[grant]; m_err[grant]=1 on the first ERR_ACK cycle.
  - Then go to IDLE, rr_ptr advances.
  - A late s_rack_vld arriving in ERR_ACK or IDLE is ignored: s_rack_rdy=0.
- Back-to-back: minimum 1 IDLE cycle between transactions; a single master requesting continuously is re-granted each time.
- Fairness: with all masters requesting, each is granted within N_REQ transactions.

Decomposition:
- Package reg_space_arb_pkg holds:
  - the state enum (3-bit);
  - the GRANT_W = $clog2(N_REQ) helper function;
  - the default ERR_DATA constant.
- One sub-module: rr_arbiter (request vector, pointer → one-hot grant plus encoded index), purely combinational and reusable elsewhere.

Test Plan:
- Single read (N_REQ=2): master0 reads addr 16'h0004, slave accepts after 2 cycles and returns 32'h1234_5678 → master0 sees data 32'h1234_5678; m_rreq_rdy[1] and m_rack_vld[1] stay 0; rr_ptr=1 afterwards.
- Contention: both masters hold writes (data 32'hA, 32'hB) continuously → slave sees the order A, B, A, B; at least 1 IDLE cycle between each.
- Same-master read+write: master1 asserts rreq_vld and wreq_vld in the same cycle → read forwarded first, write on the next grant.
- Read timeout (TIMEOUT_CYC=4): slave never asserts s_rack_vld → after 4 cycles in RD_ACK, master receives 32'hDEAD_BEEF and m_err pulses exactly 1 cycle.
- Write timeout: s_wreq_rdy held 0 (TIMEOUT_CYC=4) → after 4 cycles in WR, m_wreq_rdy and m_err pulse 1 cycle; FSM returns to IDLE.
- Reset mid-read: rst=1 while in RD_ACK → next cycle all outputs 0 and busy=0; a stale s_rack_vld afterwards is not forwarded.
